hht_control: RTL and testbench

Address sequencer for the hardware helper thread (HHT) sparse gather. It fetches the column-index and vector base addresses from the CPU register file, then streams through `csize` column indices. For each index it issues a vector read, so the gathered element `v[col[k]]` appears on the vector memory port once per cycle. The block sits between the CPU register-file read ports and two combinational memory read ports, and its downstream consumer samples `dataIn2` whenever `hht` is high.

---
 rtl/hht_control.sv | 125 ++++++++++++
 tb/tb_hht_control.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hht_control.sv
// HHT sparse-gather address sequencer: fetches bases from the register file, then streams
// csize column indices and issues one vector read per cycle. Optional macro: HHT_IDX_CHECK_EN.
module hht_control #(
  parameter int unsigned VEC_LEN = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] base_dat_a,
  input  logic [31:0] base_dat_b,
  output logic [31:0] addr1,
  output logic [31:0] addr2,
  input  logic [31:0] dataIn1,
  input  logic [31:0] dataIn2,
  input  logic        RD,
  input  logic [31:0] csize,
  input  logic [31:0] cpu_addr,
  output logic        hht,
  output logic [4:0]  regaddr1,
  output logic [4:0]  regaddr2,
  output logic [4:0]  rdata,
  output logic [4:0]  adata
);

  typedef enum logic [2:0] {S_IDLE, S_BASE0, S_BASE1, S_RUN, S_DONE} state_t;

  state_t      state_q;
  logic [31:0] k_q, col_q, addr1_q;
  logic [31:0] col_base_q, row_base_q, v_base_q, mat_base_q;
  logic        issue_v_q;
  logic [4:0]  regaddr1_q, regaddr2_q, rdata_q, adata_q;

  logic [31:0] k_d;
  logic        idx_ok_d;

  always_comb begin
    k_d = k_q + 32'd1;
`ifdef HHT_IDX_CHECK_EN
    idx_ok_d = (dataIn1 < 32'(VEC_LEN));
`else
    idx_ok_d = 1'b1;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      col_q      <= '0;
      addr1_q    <= '0;
      col_base_q <= '0;
      row_base_q <= '0;
      v_base_q   <= '0;
      mat_base_q <= '0;
      issue_v_q  <= 1'b0;
      regaddr1_q <= '0;
      regaddr2_q <= '0;
      rdata_q    <= '0;
      adata_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (RD) begin
            state_q    <= S_BASE0;
            k_q        <= '0;
            regaddr1_q <= 5'd6;
            regaddr2_q <= 5'd15;
          end
        end
        S_BASE0: begin
          col_base_q <= base_dat_a;
          row_base_q <= base_dat_b;
          rdata_q    <= cpu_addr[4:0];
          regaddr1_q <= 5'd8;
          regaddr2_q <= 5'd9;
          state_q    <= S_BASE1;
        end
        S_BASE1: begin
          v_base_q   <= base_dat_a;
          mat_base_q <= base_dat_b;
          regaddr1_q <= '0;
          regaddr2_q <= '0;
          if (csize == 32'd0) begin
            state_q <= S_DONE;
          end else begin
            state_q <= S_RUN;
            addr1_q <= col_base_q;
          end
        end
        S_RUN: begin
          // RD low freezes the whole pipeline; only the strobe drops
          if (!RD) begin
            issue_v_q <= 1'b0;
          end else if (k_q < csize) begin
            issue_v_q <= idx_ok_d;
            if (idx_ok_d) col_q <= dataIn1;
            adata_q <= k_q[4:0];
            k_q     <= k_d;
            if (k_d < csize) addr1_q <= col_base_q + k_d;
          end else begin
            issue_v_q <= 1'b0;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          if (!RD) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // addr2 is built from registers only, so it never follows dataIn1 within a cycle
  assign addr1    = addr1_q;
  assign addr2    = v_base_q + col_q;
  assign hht      = issue_v_q;
  assign regaddr1 = regaddr1_q;
  assign regaddr2 = regaddr2_q;
  assign rdata    = rdata_q;
  assign adata    = adata_q;

  // row_base/mat_base are kept for a future row stage; dataIn2 goes straight to the consumer
  logic unused_sink;
  assign unused_sink = ^{dataIn2, cpu_addr[31:5], row_base_q, mat_base_q, 32'(VEC_LEN)};

endmodule

// File: tb/tb_hht_control.sv
// Self-checking bench for hht_control: table-driven start-up vectors plus scoreboarded gathers.
module tb_hht_control;
  localparam int N_FULL = 179;
  localparam int CB     = 180;

  logic        Clk = 1'b0;
  logic        Rst, RD, hht;
  logic [31:0] base_dat_a, base_dat_b, addr1, addr2, dataIn1, dataIn2, csize, cpu_addr;
  logic [4:0]  regaddr1, regaddr2, rdata, adata;

  logic [31:0] rf     [32];
  logic [31:0] colmem [512];
  logic [31:0] vecmem [16];
  int          colv   [N_FULL];

  typedef struct { logic [4:0] adata; logic [31:0] addr2; logic [31:0] data; } exp_t;
  typedef struct { logic [4:0] ra1; logic [4:0] ra2; logic [4:0] rdata; logic hht; logic [31:0] addr1; } vec_t;
  exp_t sbq[$];
  vec_t tab[4];

  int checks = 0, errors = 0, cyc = 0;

  hht_control #(.VEC_LEN(16)) dut (
    .Clk(Clk), .Rst(Rst), .base_dat_a(base_dat_a), .base_dat_b(base_dat_b),
    .addr1(addr1), .addr2(addr2), .dataIn1(dataIn1), .dataIn2(dataIn2), .RD(RD),
    .csize(csize), .cpu_addr(cpu_addr), .hht(hht), .regaddr1(regaddr1),
    .regaddr2(regaddr2), .rdata(rdata), .adata(adata)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  assign base_dat_a = rf[regaddr1];
  assign base_dat_b = rf[regaddr2];
  assign dataIn1    = (addr1 < 32'd512) ? colmem[addr1[8:0]] : 32'd0;

  logic [31:0] voff;
  always_comb begin
    voff    = addr2 - 32'd2;
    dataIn2 = (voff < 32'd16) ? vecmem[voff[3:0]] : 32'hDEADBEEF;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every hht strobe must match the next expected gather
  always @(negedge Clk) begin : mon
    exp_t e;
    if (!Rst && hht) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_extra: hht with empty queue, adata=%0d expected none", adata);
      end else begin
        e = sbq.pop_front();
        chk("sb_addr2", addr2, e.addr2);
        chk("sb_data", dataIn2, e.data);
        chk("sb_adata", {27'd0, adata}, {27'd0, e.adata});
      end
    end
  end

  task automatic push_exp(input int n);
    logic [31:0] ci;
    for (int k = 0; k < n; k++) begin
      ci = colmem[CB + k];
`ifdef HHT_IDX_CHECK_EN
      if (ci >= 32'd16) continue;
`endif
      sbq.push_back('{adata: 5'(k), addr2: 32'd2 + ci, data: vecmem[ci[3:0]]});
    end
  endtask

  task automatic run(input int n, input int stall_at, input bit use_tab,
                     input int exp_cnt, input int exp_span);
    int cnt, first, last;
    cnt = 0; first = -1; last = -1;
    push_exp(n);
    csize = 32'(n);
    RD = 1'b1;
    for (int c = 1; c <= n + 40; c++) begin
      @(negedge Clk);
      if (use_tab && c <= 4) begin
        chk("tab_regaddr1", {27'd0, regaddr1}, {27'd0, tab[c-1].ra1});
        chk("tab_regaddr2", {27'd0, regaddr2}, {27'd0, tab[c-1].ra2});
        chk("tab_rdata", {27'd0, rdata}, {27'd0, tab[c-1].rdata});
        chk("tab_hht", {31'd0, hht}, {31'd0, tab[c-1].hht});
        chk("tab_addr1", addr1, tab[c-1].addr1);
      end
      if (hht) begin
        cnt++;
        if (first < 0) first = cyc;
        last = cyc;
        if (stall_at > 0 && cnt == stall_at) begin
          RD = 1'b0;
          repeat (3) begin
            @(negedge Clk);
            chk("stall_hht", {31'd0, hht}, 32'd0);
            chk("stall_addr1", addr1, 32'(CB + stall_at));
          end
          RD = 1'b1;
        end
      end
      if (cnt >= exp_cnt && !hht) break;
    end
    chk("hht_count", 32'(cnt), 32'(exp_cnt));
    chk("hht_span", 32'(last - first + 1), 32'(exp_span));
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    repeat (2) @(negedge Clk);
    chk("done_hht", {31'd0, hht}, 32'd0);
    chk("done_addr1", addr1, 32'(CB + n - 1));
    RD = 1'b0;
    repeat (2) @(negedge Clk);
    chk("idle_hht", {31'd0, hht}, 32'd0);
  endtask

  initial begin
    int hs, guard;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    for (int i = 0; i < 512; i++) colmem[i] = 32'd0;
    rf[6] = 32'd180; rf[8] = 32'd2; rf[15] = 32'd77; rf[9] = 32'd55;
    vecmem = '{32'd25, 32'd71, 32'd63, 32'd46, 32'd46, 32'd19, 32'd30, 32'd78,
               32'd0, 32'd44, 32'd54, 32'd35, 32'd97, 32'd59, 32'd72, 32'd80};
    colv[0] = 13;
    for (int k = 1; k < N_FULL; k++) colv[k] = int'($urandom_range(0, 15));
    for (int k = 0; k < N_FULL; k++) colmem[CB + k] = 32'(colv[k]);

    // Start-up vectors: BASE0, BASE1, first RUN cycle, first gather
    tab[0] = '{ra1: 5'd6, ra2: 5'd15, rdata: 5'd0,  hht: 1'b0, addr1: 32'd0};
    tab[1] = '{ra1: 5'd8, ra2: 5'd9,  rdata: 5'd30, hht: 1'b0, addr1: 32'd0};
    tab[2] = '{ra1: 5'd0, ra2: 5'd0,  rdata: 5'd30, hht: 1'b0, addr1: 32'd180};
    tab[3] = '{ra1: 5'd0, ra2: 5'd0,  rdata: 5'd30, hht: 1'b1, addr1: 32'd181};

    Rst = 1'b1; RD = 1'b0; csize = 32'd0; cpu_addr = 32'd126;
    repeat (2) @(negedge Clk);
    chk("rst_addr1", addr1, 32'd0);
    chk("rst_addr2", addr2, 32'd0);
    chk("rst_regaddr1", {27'd0, regaddr1}, 32'd0);
    chk("rst_regaddr2", {27'd0, regaddr2}, 32'd0);
    chk("rst_hht", {31'd0, hht}, 32'd0);
    chk("rst_rdata", {27'd0, rdata}, 32'd0);
    chk("rst_adata", {27'd0, adata}, 32'd0);
    Rst = 1'b0;
    @(negedge Clk);

    run(N_FULL, 0, 1'b1, N_FULL, N_FULL);
    run(20, 5, 1'b0, 20, 23);

    // Empty run: BASE1 goes straight to DONE
    csize = 32'd0; RD = 1'b1; hs = 0;
    repeat (8) begin @(negedge Clk); if (hht) hs++; end
    chk("empty_hht", 32'(hs), 32'd0);
    RD = 1'b0;
    repeat (2) @(negedge Clk);

`ifdef HHT_IDX_CHECK_EN
    colmem[CB + 2] = 32'd99999;
    run(6, 0, 1'b0, 5, 6);
    colmem[CB + 2] = 32'(colv[2]);
`endif

    // Reset in the middle of a run
    push_exp(N_FULL);
    csize = 32'(N_FULL); RD = 1'b1; hs = 0; guard = 0;
    while (hs < 10 && guard < 100) begin
      @(negedge Clk); guard++;
      if (hht) hs++;
    end
    chk("midrst_reached", 32'(hs), 32'd10);
    Rst = 1'b1;
    @(negedge Clk);
    chk("midrst_hht", {31'd0, hht}, 32'd0);
    chk("midrst_addr1", addr1, 32'd0);
    chk("midrst_addr2", addr2, 32'd0);
    chk("midrst_adata", {27'd0, adata}, 32'd0);
    chk("midrst_rdata", {27'd0, rdata}, 32'd0);
    sbq.delete();
    @(negedge Clk);
    Rst = 1'b0; RD = 1'b0; hs = 0;
    repeat (4) begin @(negedge Clk); if (hht) hs++; end
    chk("postrst_hht", 32'(hs), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
